exp3_datapath: RTL and testbench
================================

Name: exp3_datapath

Overview:
- Datapath of the Exp. 3 memory-sequence game.
- A 4-bit address counter drives a fixed 16x4 ROM.
- A 4-bit register captures the player's switches, and a comparator flags when the captured value equals the current ROM word.
- Driven by an external control unit via zeraC/contaC/zeraR/registraR; db_* outputs feed debug displays.

Parameters:
- None. Data width (4), address width (4) and ROM contents are fixed.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset of counter and register.
- zeraC  input  1  synchronous clear of address counter, active-high.
- contaC  input  1  counter increment enable, active-high.
- zeraR  input  1  synchronous clear of switch register, active-high.
- registraR  input  1  switch register load enable, active-high.
- chaves  input  4  player switch inputs.
- chavesIgualMemoria  output  1  1 when register value == ROM word at current address.
- fimC  output  1  1 when counter == 15.
- db_contagem  output  4  current counter value (ROM address).
- db_chaves  output  4  current register value.
- db_memoria  output  4  ROM word at current address.

Behaviour:
- Reset: reset_n=0 forces counter=0 and register=0 immediately, independent of clock.
  - While reset_n=0: db_contagem=0000, db_chaves=0000, db_memoria=0001, fimC=0, chavesIgualMemoria=0.
- Counter (4-bit, rising edge, reset_n=1):
  - zeraC=1: count <= 0. zeraC has priority over contaC.
  - else contaC=1: count <= count+1, wrapping 15 -> 0.
  - else: hold.
- fimC is combinational: 1 exactly when count==1111.
- Register (4-bit, rising edge, reset_n=1):
  - zeraR=1: value <= 0. zeraR has priority over registraR.
  - else registraR=1: value <= chaves.
  - else: hold.
  - chaves changes without registraR do not affect outputs.
- ROM: asynchronous (combinational) read, address = count, zero-cycle latency. Contents, addresses 0..15:
  - 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001,
  - 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- Comparator: chavesIgualMemoria = (register value == ROM word), combinational, all 4 bits compared.
- Debug outputs: db_contagem = count; db_chaves = register value; db_memoria = ROM word.
- Counter and register are independent: simultaneous contaC and registraR both take effect on the same edge.
  - Comparison then uses the new address and the new register value in the following cycle.
- Boundary conditions:
  - No outputs are registered beyond the counter and register themselves.
  - No output is undefined after reset; all outputs are valid from the first cycle after reset_n deasserts.

Test Plan:
1. reset_n pulse low, then zeraC=zeraR=1 for one clock -> db_contagem=0000, db_chaves=0000, db_memoria=0001, fimC=0, chavesIgualMemoria=0.
2. chaves=0001 with registraR=0 -> db_chaves stays 0000, igual=0. Then registraR=1 for one clock -> db_chaves=0001, igual=1.
3. contaC=1 for one clock -> address 0001, db_memoria=0010, igual=0. Then register chaves=0010 -> igual=1.
4. contaC=1 for one clock -> address 0010, db_memoria=0100. Then register chaves=1000 -> db_chaves=1000, igual=0.
5. 13 further single-cycle contaC pulses -> db_contagem=1111, db_memoria=0100, fimC=1. One more pulse -> count wraps to 0000, fimC=0.
6. Priority and asynchronous reset:
   - zeraC=contaC=1 together -> count=0000.
   - zeraR=registraR=1 together -> register=0000.
   - reset_n=0 asserted mid-cycle -> counter and register clear before the next edge.

Source files
------------

// File: rtl/exp3_datapath.sv
// exp3_datapath
// Datapath of the Exp. 3 memory-sequence game. A 4-bit address counter
// walks a fixed 16x4 ROM holding the sequence the player must repeat.
// A 4-bit register captures the player's switches, and a comparator flags
// when the captured value matches the ROM word at the current address.
// An external control unit sequences everything through zeraC/contaC and
// zeraR/registraR.
//
// Ports:
//   clock              in   1  system clock, rising-edge active
//   reset_n            in   1  asynchronous active-low reset (counter, register)
//   zeraC              in   1  synchronous counter clear (wins over contaC)
//   contaC             in   1  counter increment enable
//   zeraR              in   1  synchronous register clear (wins over registraR)
//   registraR          in   1  register load enable (captures chaves)
//   chaves             in   4  player switches
//   chavesIgualMemoria out  1  register value equals current ROM word
//   fimC               out  1  counter is at its last address (15)
//   db_contagem        out  4  counter value / ROM address (debug)
//   db_chaves          out  4  register value (debug)
//   db_memoria         out  4  ROM word at current address (debug)

module exp3_datapath (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       zeraC,
    input  logic       contaC,
    input  logic       zeraR,
    input  logic       registraR,
    input  logic [3:0] chaves,
    output logic       chavesIgualMemoria,
    output logic       fimC,
    output logic [3:0] db_contagem,
    output logic [3:0] db_chaves,
    output logic [3:0] db_memoria
);

    logic [3:0] contagem;
    logic [3:0] valorChaves;
    logic [3:0] palavraMemoria;

    // Address counter: clear has priority over counting; the 4-bit
    // addition wraps naturally from 15 back to 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            contagem <= 4'd0;
        end else if (zeraC) begin
            contagem <= 4'd0;
        end else if (contaC) begin
            contagem <= contagem + 4'd1;
        end
    end

    // Switch register: clear has priority over loading, otherwise the
    // stored value holds no matter how the switches move.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valorChaves <= 4'd0;
        end else if (zeraR) begin
            valorChaves <= 4'd0;
        end else if (registraR) begin
            valorChaves <= chaves;
        end
    end

    // Fixed game sequence, read combinationally so the word follows the
    // address in the same cycle the counter changes.
    always_comb begin
        palavraMemoria = 4'b0001;
        case (contagem)
            4'd0:  palavraMemoria = 4'b0001;
            4'd1:  palavraMemoria = 4'b0010;
            4'd2:  palavraMemoria = 4'b0100;
            4'd3:  palavraMemoria = 4'b1000;
            4'd4:  palavraMemoria = 4'b0100;
            4'd5:  palavraMemoria = 4'b0010;
            4'd6:  palavraMemoria = 4'b0001;
            4'd7:  palavraMemoria = 4'b0001;
            4'd8:  palavraMemoria = 4'b0010;
            4'd9:  palavraMemoria = 4'b0010;
            4'd10: palavraMemoria = 4'b0100;
            4'd11: palavraMemoria = 4'b0100;
            4'd12: palavraMemoria = 4'b1000;
            4'd13: palavraMemoria = 4'b1000;
            4'd14: palavraMemoria = 4'b0001;
            4'd15: palavraMemoria = 4'b0100;
            default: palavraMemoria = 4'b0001;
        endcase
    end

    assign chavesIgualMemoria = (valorChaves == palavraMemoria);
    assign fimC               = (contagem == 4'b1111);
    assign db_contagem        = contagem;
    assign db_chaves          = valorChaves;
    assign db_memoria         = palavraMemoria;

endmodule

// File: tb/tb_exp3_datapath.sv
// tb_exp3_datapath
// Directed bench for exp3_datapath: walks the counter through the whole
// ROM, loads and clears the switch register, exercises clear priority and
// the asynchronous reset. Expected values are hand-written constants.

module tb_exp3_datapath;

    logic       clock;
    logic       reset_n;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic [3:0] chaves;
    logic       chavesIgualMemoria;
    logic       fimC;
    logic [3:0] db_contagem;
    logic [3:0] db_chaves;
    logic [3:0] db_memoria;

    int errorCount = 0;
    int checkCount = 0;

    // Hand-copied game sequence used as the reference for the ROM walk.
    logic [3:0] romEsperada [16] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
        4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100
    };

    exp3_datapath dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .zeraC              (zeraC),
        .contaC             (contaC),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .chaves             (chaves),
        .chavesIgualMemoria (chavesIgualMemoria),
        .fimC               (fimC),
        .db_contagem        (db_contagem),
        .db_chaves          (db_chaves),
        .db_memoria         (db_memoria)
    );

    // 10-time-unit clock period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts, and on a miss reports and flags it.
    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
            $error("[TB] check %s failed", tag);
        end
    endtask

    // Checks every output against the expected set.
    task automatic checkAll(input string tag, input logic [3:0] expCont,
                            input logic [3:0] expChaves, input logic [3:0] expMem,
                            input logic expFim, input logic expIgual);
        checkOutput({tag, ".contagem"}, db_contagem, expCont);
        checkOutput({tag, ".chaves"},   db_chaves,   expChaves);
        checkOutput({tag, ".memoria"},  db_memoria,  expMem);
        checkOutput({tag, ".fimC"},     {3'b000, fimC}, {3'b000, expFim});
        checkOutput({tag, ".igual"},    {3'b000, chavesIgualMemoria}, {3'b000, expIgual});
    endtask

    // Holds the control inputs already set for one rising edge, then
    // returns #1 after the edge with all control inputs back to idle.
    task automatic applyStimulus;
        @(posedge clock);
        #1;
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        chaves    = 4'b0000;

        // Outputs while reset is held.
        #3;
        checkAll("inReset", 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Initial clear by the control unit.
        zeraC = 1'b1;
        zeraR = 1'b1;
        applyStimulus();
        checkAll("clear", 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);

        // Switches move without a load: nothing visible changes.
        chaves = 4'b0001;
        applyStimulus();
        checkAll("noLoad", 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);

        // Load matches address 0.
        registraR = 1'b1;
        applyStimulus();
        checkAll("load0", 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b1);

        // Advance to address 1: word 0010 no longer matches 0001.
        contaC = 1'b1;
        applyStimulus();
        checkAll("addr1", 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0);

        chaves    = 4'b0010;
        registraR = 1'b1;
        applyStimulus();
        checkAll("load1", 4'b0001, 4'b0010, 4'b0010, 1'b0, 1'b1);

        // Idle cycle: counter and register hold.
        applyStimulus();
        checkAll("hold", 4'b0001, 4'b0010, 4'b0010, 1'b0, 1'b1);

        // Address 2, then load a non-matching value.
        contaC = 1'b1;
        applyStimulus();
        checkAll("addr2", 4'b0010, 4'b0010, 4'b0100, 1'b0, 1'b0);

        chaves    = 4'b1000;
        registraR = 1'b1;
        applyStimulus();
        checkAll("load2", 4'b0010, 4'b1000, 4'b0100, 1'b0, 1'b0);

        // Walk addresses 3..15, checking address and ROM word each step.
        for (int a = 3; a <= 15; a++) begin
            contaC = 1'b1;
            applyStimulus();
            checkOutput($sformatf("walk%0d.contagem", a), db_contagem, 4'(a));
            checkOutput($sformatf("walk%0d.memoria", a), db_memoria, romEsperada[a]);
        end
        checkAll("last", 4'b1111, 4'b1000, 4'b0100, 1'b1, 1'b0);

        // Wrap back to 0.
        contaC = 1'b1;
        applyStimulus();
        checkAll("wrap", 4'b0000, 4'b1000, 4'b0001, 1'b0, 1'b0);

        // Count and load on the same edge; compare uses both new values.
        chaves    = 4'b0010;
        contaC    = 1'b1;
        registraR = 1'b1;
        applyStimulus();
        checkAll("both", 4'b0001, 4'b0010, 4'b0010, 1'b0, 1'b1);

        // Clear wins over count.
        zeraC  = 1'b1;
        contaC = 1'b1;
        applyStimulus();
        checkAll("prioC", 4'b0000, 4'b0010, 4'b0001, 1'b0, 1'b0);

        // Clear wins over load.
        chaves    = 4'b1111;
        zeraR     = 1'b1;
        registraR = 1'b1;
        applyStimulus();
        checkAll("prioR", 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);

        // Put non-zero state back, then reset in the middle of a cycle.
        chaves    = 4'b0101;
        contaC    = 1'b1;
        registraR = 1'b1;
        applyStimulus();
        checkAll("preReset", 4'b0001, 4'b0101, 4'b0010, 1'b0, 1'b0);

        #2;
        reset_n = 1'b0;
        #1;
        checkAll("asyncReset", 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus();
        checkAll("afterReset", 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
